// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scanner.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package seg_pkg;

   localparam int DIGITS = 4;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      ARM  = 2'd1,
      SCAN = 2'd2
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seven_seg_scan.sv
// 4-digit common-anode scanner with per-frame shadow latch, registered outputs.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_seg_scan
   import seg_pkg::*;
#(
   parameter int CLK_DIV = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [15:0]       value,
   input  logic [DIGITS-1:0] dp_in,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] an,
   output logic              frame_done
);

   localparam int PW = $clog2(CLK_DIV + 1);
   localparam logic [PW-1:0] TOP = PW'(CLK_DIV - 1);

   state_e            state_q;
   logic [PW-1:0]     presc_q;
   logic [1:0]        idx_q, idx_d;
   logic [15:0]       shadow_q, shadow_d;
   logic [DIGITS-1:0] sdp_q, sdp_d;
   logic [DIGITS-1:0] an_q;
   logic [6:0]        seg_q;
   logic              dp_q, fd_q;

   logic              tick, load, lz;
   logic [3:0]        nib;
   logic [6:0]        dec;

   assign tick = (presc_q == TOP);

   // Next index and shadow as they will be after this edge;
   // the outputs are decoded from these so they move together.
   always_comb begin
      load  = 1'b0;
      idx_d = idx_q;
      if (tick) begin
         case (state_q)
            ARM: begin
               load  = 1'b1;
               idx_d = 2'd0;
            end
            SCAN: begin
               load  = (idx_q == 2'd3);
               idx_d = idx_q + 2'd1;
            end
            default: ;
         endcase
      end
      shadow_d = load ? value : shadow_q;
      sdp_d    = load ? dp_in : sdp_q;
   end

   assign nib = shadow_d[{idx_d, 2'b00} +: 4];

   hex_to_seg u_dec (
      .nib_i (nib),
      .seg_o (dec)
   );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   always_comb begin
      lz = 1'b0;
      case (idx_d)
         2'd3:    lz = (shadow_d[15:12] == 4'h0);
         2'd2:    lz = (shadow_d[15:8] == 8'h0);
         2'd1:    lz = (shadow_d[15:4] == 12'h0);
         default: lz = 1'b0;
      endcase
   end
`else
   assign lz = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= OFF;
         presc_q  <= '0;
         idx_q    <= 2'd0;
         shadow_q <= 16'h0000;
         sdp_q    <= '0;
         an_q     <= '1;
         seg_q    <= SEG_BLANK;
         dp_q     <= 1'b1;
         fd_q     <= 1'b0;
      end else if (!enable) begin
         state_q <= OFF;
         presc_q <= '0;
         an_q    <= '1;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         fd_q    <= 1'b0;
         presc_q <= tick ? '0 : presc_q + PW'(1);
         case (state_q)
            OFF: begin
               state_q <= ARM;
               presc_q <= '0;
            end
            ARM, SCAN: begin
               if (tick) begin
                  state_q  <= SCAN;
                  idx_q    <= idx_d;
                  shadow_q <= shadow_d;
                  sdp_q    <= sdp_d;
                  fd_q     <= load;
                  if (lz) begin
                     an_q  <= '1;
                     seg_q <= SEG_BLANK;
                     dp_q  <= 1'b1;
                  end else begin
                     an_q  <= ~(4'b0001 << idx_d);
                     seg_q <= dec;
                     dp_q  <= ~sdp_d[idx_d];
                  end
               end
            end
            default: state_q <= OFF;
         endcase
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: directed slot table plus random run against a
// cycle-age reference model, on CLK_DIV=4 and CLK_DIV=1 instances.
module tb_seven_seg_scan;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [15:0] value = 16'h0000;
   logic [3:0]  dp_in = 4'h0;

   logic [6:0]  seg4, seg1;
   logic        dp4, dp1;
   logic [3:0]  an4, an1;
   logic        fd4, fd1;

   int errors = 0;
   int checks = 0;

   // Edges since the display was (re)enabled; 0 while reset or disabled.
   int age = 0;
   logic [15:0] sh4 = 16'h0, sh1 = 16'h0;
   logic [3:0]  sd4 = 4'h0, sd1 = 4'h0;

   localparam logic [12:0] BLANK = {4'b1111, 7'b1111111, 1'b1, 1'b0};

   logic [6:0] ref_seg [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef struct {
      logic [15:0] v;
      logic [3:0]  dpi;
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic        fd;
   } vec_t;

   vec_t tbl [9];

   seven_seg_scan #(.CLK_DIV(4)) u_dut4 (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .value      (value),
      .dp_in      (dp_in),
      .seg        (seg4),
      .dp         (dp4),
      .an         (an4),
      .frame_done (fd4)
   );

   seven_seg_scan #(.CLK_DIV(1)) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .value      (value),
      .dp_in      (dp_in),
      .seg        (seg1),
      .dp         (dp1),
      .an         (an1),
      .frame_done (fd1)
   );

   always #5 clk = ~clk;

   function automatic logic frame_start(int a, int div);
      return (a >= div + 1) && ((a - 1 - div) % (4 * div) == 0);
   endfunction

   function automatic logic [12:0] ref_out(int a, int div,
                                          logic [15:0] sh,
                                          logic [3:0] sd);
      int s, d;
      logic [15:0] hi;
      logic fd;
      if (a <= div) return BLANK;
      s  = (a - 1 - div) / div;
      d  = s % 4;
      fd = ((a - 1 - div) % div == 0) && (d == 0);
      hi = sh >> (4 * d);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (d != 0 && hi == 16'h0) return BLANK;
`endif
      return {~(4'b0001 << d), ref_seg[hi[3:0]], ~sd[d], fd};
   endfunction

   task automatic chk(string name, logic [12:0] got, logic [12:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
                  name, got[12:9], got[8:2], got[1], got[0],
                  exp[12:9], exp[8:2], exp[1], exp[0]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset || !enable) age = 0;
      else age++;
      if (frame_start(age, 4)) begin
         sh4 = value;
         sd4 = dp_in;
      end
      if (frame_start(age, 1)) begin
         sh1 = value;
         sd1 = dp_in;
      end
      #1;
      chk("model_div4", {an4, seg4, dp4, fd4}, ref_out(age, 4, sh4, sd4));
      chk("model_div1", {an1, seg1, dp1, fd1}, ref_out(age, 1, sh1, sd1));
   endtask

   initial begin
      tbl[0] = '{16'h1A8F, 4'b0100, 4'b1110, 7'b0001110, 1'b1, 1'b1};
      tbl[1] = '{16'h1A8F, 4'b0100, 4'b1101, 7'b0000000, 1'b1, 1'b0};
      tbl[2] = '{16'h1A8F, 4'b0100, 4'b1011, 7'b0001000, 1'b0, 1'b0};
      tbl[3] = '{16'h1A8F, 4'b0100, 4'b0111, 7'b1111001, 1'b1, 1'b0};
      tbl[4] = '{16'h1A8F, 4'b0100, 4'b1110, 7'b0001110, 1'b1, 1'b1};
      tbl[5] = '{16'h0000, 4'b0100, 4'b1101, 7'b0000000, 1'b1, 1'b0};
      tbl[6] = '{16'h0000, 4'b0100, 4'b1011, 7'b0001000, 1'b0, 1'b0};
      tbl[7] = '{16'h0000, 4'b0100, 4'b0111, 7'b1111001, 1'b1, 1'b0};
      tbl[8] = '{16'h1A8F, 4'b0100, 4'b1110, 7'b1000000, 1'b1, 1'b1};

      reset  = 1'b1;
      enable = 1'b1;
      value  = 16'h1A8F;
      dp_in  = 4'b0100;
      repeat (3) begin
         step();
         chk("reset_blank", {an4, seg4, dp4, fd4}, BLANK);
      end
      reset = 1'b0;
      repeat (4) begin
         step();
         chk("arm_blank", {an4, seg4, dp4, fd4}, BLANK);
      end

      // Each record is one digit slot; its inputs change mid-slot.
      for (int i = 0; i < 9; i++) begin
         for (int j = 0; j < 4; j++) begin
            step();
            chk($sformatf("vec%0d", i), {an4, seg4, dp4, fd4},
                {tbl[i].an, tbl[i].seg, tbl[i].dp,
                 (j == 0) ? tbl[i].fd : 1'b0});
            if (j == 0) begin
               value = tbl[i].v;
               dp_in = tbl[i].dpi;
            end
         end
      end

      repeat (20) step();
      step();
      chk("pre_drop", {an4, seg4, dp4, fd4},
          {4'b1011, 7'b0001000, 1'b0, 1'b0});
      enable = 1'b0;
      step();
      chk("enable_drop", {an4, seg4, dp4, fd4}, BLANK);
      enable = 1'b1;
      repeat (4) begin
         step();
         chk("rearm_blank", {an4, seg4, dp4, fd4}, BLANK);
      end
      step();
      chk("restart", {an4, seg4, dp4, fd4},
          {4'b1110, 7'b0001110, 1'b1, 1'b1});

      for (int n = 0; n < 3000; n++) begin
         logic [15:0] v;
         v = 16'($urandom);
         for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
         value  = v;
         dp_in  = 4'($urandom);
         reset  = ($urandom_range(0, 299) == 0);
         enable = ($urandom_range(0, 59) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
